load_store_unit: RTL and testbench

Sits between the pipeline MEM stage and `dataMemory`, accepting one load or store request per cycle over a valid/ready handshake. Stores are posted into a small in-order store buffer and drained to memory in cycles when no load uses the port. Loads read memory combinationally, are checked against buffered stores for hazards, and return a registered response one cycle later.

---
 rtl/load_store_unit_pkg.sv | 44 ++++
 rtl/load_store_unit_if.sv | 25 ++
 rtl/load_store_unit_store_buffer.sv | 86 ++++++++
 rtl/load_store_unit.sv | 102 ++++++++++
 tb/tb_load_store_unit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: access-size encodings,
// store-buffer entry layout, access width and load extension.
package lsu_pkg;

   localparam int LSU_DATA_WIDTH = 32;
   localparam int LSU_ADDR_WIDTH = 17;

   // SizeCtr encodings; SZ_IDLE doubles as the "no access" port value.
   localparam logic [2:0] SZ_B    = 3'b000;
   localparam logic [2:0] SZ_H    = 3'b001;
   localparam logic [2:0] SZ_W    = 3'b010;
   localparam logic [2:0] SZ_BU   = 3'b100;
   localparam logic [2:0] SZ_HU   = 3'b101;
   localparam logic [2:0] SZ_IDLE = 3'b011;

   typedef struct packed {
      logic [LSU_ADDR_WIDTH-1:0] addr;
      logic [2:0]                size;
      logic [LSU_DATA_WIDTH-1:0] data;
   } sb_entry_t;

   // Bytes touched by an access; 0 marks an invalid encoding.
   function automatic logic [2:0] size_bytes(input logic [2:0] size);
      case (size)
         SZ_B, SZ_BU: return 3'd1;
         SZ_H, SZ_HU: return 3'd2;
         SZ_W:        return 3'd4;
         default:     return 3'd0;
      endcase
   endfunction

   function automatic logic [LSU_DATA_WIDTH-1:0] extend_load(input logic [LSU_DATA_WIDTH-1:0] data,
                                                              input logic [2:0]                size);
      case (size)
         SZ_B:    return {{24{data[7]}}, data[7:0]};
         SZ_BU:   return {24'b0, data[7:0]};
         SZ_H:    return {{16{data[15]}}, data[15:0]};
         SZ_HU:   return {16'b0, data[15:0]};
         SZ_W:    return data;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bundle between the MEM stage (master) and the load/store unit (slave).
interface load_store_unit_if #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [2:0]            req_size;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  sb_empty;

   modport master (
      output req_valid, req_write, req_size, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, sb_empty
   );

   modport slave (
      input  req_valid, req_write, req_size, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, sb_empty
   );
endinterface

// File: rtl/load_store_unit_store_buffer.sv
// In-order circular store buffer with a combinational byte-overlap scan
// that reports any hit and whether the youngest hit exactly matches the load.
module store_buffer
   import lsu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  sb_entry_t                 push_entry,
   input  logic                      pop,
   output sb_entry_t                 head_entry,
   output logic                      full,
   output logic                      empty,
   output logic                      sb_empty,
   input  logic [LSU_ADDR_WIDTH-1:0] scan_addr,
   input  logic [2:0]                scan_size,
   output logic                      hit_any,
   output logic                      hit_exact_youngest,
   output logic [LSU_DATA_WIDTH-1:0] fwd_data
);
   localparam int PTR_W = $clog2(DEPTH);

   sb_entry_t        entries [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_nxt;

   assign full       = (count == (PTR_W+1)'(DEPTH));
   assign empty      = (count == '0);
   assign head_entry = entries[head];
   assign count_nxt  = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         sb_empty <= 1'b1;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count    <= count_nxt;
         sb_empty <= (count_nxt == '0);
      end
   end

   // NOTE: entry storage is not reset; occupancy is tracked by count alone, so stale slots are never observed.
   always_ff @(posedge clk) begin
      if (push) entries[tail] <= push_entry;
   end

   // Oldest-to-youngest walk: the last hit seen is the youngest overlapping entry.
   // NOTE: every output and temporary gets a default first so no latch is inferred.
   always_comb begin
      logic [PTR_W-1:0]          idx;
      logic [LSU_ADDR_WIDTH:0]   ld_lo, ld_hi, st_lo, st_hi;
      sb_entry_t                 e;
      hit_any            = 1'b0;
      hit_exact_youngest = 1'b0;
      fwd_data           = '0;
      idx                = '0;
      e                  = '0;
      ld_lo              = {1'b0, scan_addr};
      ld_hi              = ld_lo + (LSU_ADDR_WIDTH+1)'(size_bytes(scan_size));
      st_lo              = '0;
      st_hi              = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx   = head + PTR_W'(i);
         e     = entries[idx];
         st_lo = {1'b0, e.addr};
         st_hi = st_lo + (LSU_ADDR_WIDTH+1)'(size_bytes(e.size));
         if (((PTR_W+1)'(i) < count) && (ld_hi != ld_lo) &&
             (ld_lo < st_hi) && (st_lo < ld_hi)) begin
            hit_any            = 1'b1;
            hit_exact_youngest = (e.addr == scan_addr) &&
                                 (size_bytes(e.size) == size_bytes(scan_size));
            fwd_data           = e.data;
         end
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and dataMemory: posted stores, hazard-checked
// loads with a registered response. Define LSU_FWD_EN to forward exact-match stores.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = LSU_DATA_WIDTH,
   parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   load_store_unit_if.slave      lsu,
   output logic                  MemWrite,
   output logic [2:0]            SizeCtr,
   output logic [ADDR_WIDTH-1:0] ALUResult,
   output logic [DATA_WIDTH-1:0] WriteData,
   input  logic [DATA_WIDTH-1:0] ReadData
);
   sb_entry_t             head_entry;
   sb_entry_t             push_entry;
   logic                  sb_full;
   logic                  sb_empty_now;
   logic                  hit_any;
   logic                  hit_exact;
   logic [DATA_WIDTH-1:0] fwd_data;
   logic                  fwd_ok;
   logic                  is_load;
   logic                  is_store;
   logic                  ld_stall;
   logic                  ld_fwd;
   logic                  ld_accept;
   logic                  drain;
   logic                  push;

`ifdef LSU_FWD_EN
   assign fwd_ok = hit_exact;
`else
   assign fwd_ok = 1'b0;
`endif

   assign push_entry = '{addr: lsu.req_addr, size: lsu.req_size, data: lsu.req_wdata};

   always_comb begin
      is_load   = lsu.req_valid & ~lsu.req_write;
      is_store  = lsu.req_valid &  lsu.req_write;
      ld_stall  = is_load & hit_any & ~fwd_ok;
      ld_fwd    = is_load & hit_any &  fwd_ok;
      ld_accept = is_load & ~ld_stall;
      drain     = ~ld_accept & ~sb_empty_now;
      // A full buffer still takes a store because the head drains in any non-load cycle.
      lsu.req_ready = lsu.req_write ? (~sb_full | drain) : ~ld_stall;
      push      = is_store & lsu.req_ready & (size_bytes(lsu.req_size) != 3'd0);
   end

   store_buffer #(.DEPTH(DEPTH)) u_store_buffer (
      .clk                (clk),
      .rst_n              (rst_n),
      .push               (push),
      .push_entry         (push_entry),
      .pop                (drain),
      .head_entry         (head_entry),
      .full               (sb_full),
      .empty              (sb_empty_now),
      .sb_empty           (lsu.sb_empty),
      .scan_addr          (lsu.req_addr),
      .scan_size          (lsu.req_size),
      .hit_any            (hit_any),
      .hit_exact_youngest (hit_exact),
      .fwd_data           (fwd_data)
   );

   // Memory port: a memory-bound load wins, otherwise the head drains, otherwise idle.
   always_comb begin
      MemWrite  = 1'b0;
      SizeCtr   = SZ_IDLE;
      ALUResult = '0;
      WriteData = '0;
      if (ld_accept && !ld_fwd) begin
         SizeCtr   = lsu.req_size;
         ALUResult = lsu.req_addr;
      end else if (drain) begin
         MemWrite  = 1'b1;
         SizeCtr   = head_entry.size;
         ALUResult = head_entry.addr;
         WriteData = head_entry.data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lsu.rsp_valid <= 1'b0;
         lsu.rsp_rdata <= '0;
      end else begin
         lsu.rsp_valid <= ld_accept;
         if (ld_accept) begin
            lsu.rsp_rdata <= ld_fwd ? extend_load(fwd_data, lsu.req_size)
                                    : extend_load(ReadData, lsu.req_size);
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array reference memory updated in
// program order, with scoreboards for load responses and drained stores.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam int AW        = 17;
   localparam int DW        = 32;
   localparam int MEM_BYTES = 8192;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   load_store_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) lsu ();

   logic          MemWrite;
   logic [2:0]    SizeCtr;
   logic [AW-1:0] ALUResult;
   logic [DW-1:0] WriteData;
   logic [DW-1:0] ReadData;

   load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lsu       (lsu),
      .MemWrite  (MemWrite),
      .SizeCtr   (SizeCtr),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ReadData  (ReadData)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Access width straight from the size encoding table; 0 = invalid.
   function automatic int acc_width(input logic [2:0] s);
      case (s)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic logic [31:0] width_mask(input int w);
      return (w >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * w)) - 32'h1);
   endfunction

   // ---------------- dataMemory model (combinational read, write at edge) ----------------
   logic [7:0] mem [MEM_BYTES];

   assign ReadData = {mem[13'(ALUResult + 17'd3)], mem[13'(ALUResult + 17'd2)],
                      mem[13'(ALUResult + 17'd1)], mem[13'(ALUResult)]};

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i * 37 + 11);
      forever begin
         @(posedge clk);
         if (MemWrite) begin
            for (int k = 0; k < acc_width(SizeCtr); k++)
               mem[13'(ALUResult + 17'(k))] <= WriteData[8*k +: 8];
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- architectural reference model ----------------
   logic [7:0] ref_mem [MEM_BYTES];

   function automatic logic [31:0] ref_load(input logic [16:0] a, input logic [2:0] s);
      int     w;
      longint v;
      w = acc_width(s);
      v = 0;
      if (w == 0) return 32'h0;
      for (int k = 0; k < w; k++) v += longint'(ref_mem[13'(a + 17'(k))]) << (8 * k);
      if (s[2] == 1'b0 && v >= (longint'(1) << (8 * w - 1))) v -= (longint'(1) << (8 * w));
      return 32'(v);
   endfunction

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } rsp_exp_t;

   typedef struct {
      logic [16:0] addr;
      logic [2:0]  size;
      logic [31:0] data;
   } st_exp_t;

   rsp_exp_t rsp_q [$];
   st_exp_t  st_q  [$];

   // ---------------- monitor: load responses and memory writes ----------------
   always @(negedge clk) begin
      rsp_exp_t re;
      st_exp_t  se;
      if (rst_n) begin
         if (lsu.rsp_valid) begin
            check("rsp_was_expected", 64'(rsp_q.size() > 0), 64'd1);
            if (rsp_q.size() > 0) begin
               re = rsp_q.pop_front();
               check("rsp_rdata", 64'(lsu.rsp_rdata), 64'(re.data));
               check("rsp_latency_cycle", 64'(cyc), 64'(re.cyc));
            end
         end
         if (MemWrite) begin
            check("memwrite_was_expected", 64'(st_q.size() > 0), 64'd1);
            if (st_q.size() > 0) begin
               se = st_q.pop_front();
               check("drain_addr", 64'(ALUResult), 64'(se.addr));
               check("drain_size", 64'(SizeCtr), 64'(se.size));
               check("drain_data", 64'(WriteData & width_mask(acc_width(se.size))),
                                   64'(se.data & width_mask(acc_width(se.size))));
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic issue(input logic wr, input logic [2:0] sz, input logic [16:0] a,
                        input logic [31:0] d, input bit model, output int stalls);
      bit accepted;
      stalls          = 0;
      accepted        = 1'b0;
      lsu.req_valid   = 1'b1;
      lsu.req_write   = wr;
      lsu.req_size    = sz;
      lsu.req_addr    = a;
      lsu.req_wdata   = d;
      while (!accepted) begin
         @(negedge clk);
         if (lsu.req_ready) begin
            accepted = 1'b1;
         end else begin
            stalls++;
            if (stalls > 40) begin
               check("req_ready_within_budget", 64'(lsu.req_ready), 64'd1);
               break;
            end
            @(posedge clk);
            #1;
         end
      end
      if (accepted && model) begin
         if (wr) begin
            if (acc_width(sz) != 0) begin
               for (int k = 0; k < acc_width(sz); k++) ref_mem[13'(a + 17'(k))] = d[8*k +: 8];
               st_q.push_back('{addr: a, size: sz, data: d});
            end
         end else begin
            check("load_cycle_memwrite", 64'(MemWrite), 64'd0);
            rsp_q.push_back('{data: ref_load(a, sz), cyc: cyc + 1});
         end
      end
      @(posedge clk);
      #1;
      lsu.req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int          st;
      int          exp_fwd_stall;
      logic [2:0]  size_tbl [12];
      logic        wr;
      logic [2:0]  sz;
      logic [16:0] a;

      size_tbl = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                   3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i * 37 + 11);

      lsu.req_valid = 1'b0;
      lsu.req_write = 1'b0;
      lsu.req_size  = 3'b000;
      lsu.req_addr  = '0;
      lsu.req_wdata = '0;

      // Reset state
      #12;
      check("reset_rsp_valid", 64'(lsu.rsp_valid), 64'd0);
      check("reset_rsp_rdata", 64'(lsu.rsp_rdata), 64'd0);
      check("reset_sb_empty", 64'(lsu.sb_empty), 64'd1);
      check("reset_memwrite", 64'(MemWrite), 64'd0);
      check("reset_idle_sizectr", 64'(SizeCtr), 64'(3'b011));
      check("reset_req_ready", 64'(lsu.req_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // Reset while the head is draining: the store must vanish
      issue(1'b1, SZ_W, 17'h1000, 32'h1122_3344, 1'b0, st);
      check("pre_reset_drain_memwrite", 64'(MemWrite), 64'd1);
      check("pre_reset_sb_empty", 64'(lsu.sb_empty), 64'd0);
      #1 rst_n = 1'b0;
      #1;
      check("midreset_memwrite", 64'(MemWrite), 64'd0);
      check("midreset_sb_empty", 64'(lsu.sb_empty), 64'd1);
      check("midreset_rsp_valid", 64'(lsu.rsp_valid), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_reset_memwrite", 64'(MemWrite), 64'd0);
      idle(1);
      check("post_reset_memwrite_next", 64'(MemWrite), 64'd0);
      issue(1'b0, SZ_W, 17'h1000, 32'h0, 1'b1, st);

      // Store then adjacent, non-overlapping load
      issue(1'b1, SZ_W, 17'h0100, 32'hDEAD_BEEF, 1'b1, st);
      check("sb_empty_after_push", 64'(lsu.sb_empty), 64'd0);
      issue(1'b0, SZ_W, 17'h0104, 32'h0, 1'b1, st);
      check("adjacent_load_stalls", 64'(st), 64'd0);
      idle(2);
      issue(1'b0, SZ_W, 17'h0100, 32'h0, 1'b1, st);

      // Five back-to-back stores: never back-pressured, drained in order
      for (int i = 0; i < 5; i++) begin
         issue(1'b1, SZ_W, 17'h0180 + 17'(4 * i), 32'hA5A5_0000 + 32'(i), 1'b1, st);
         check("store_stream_stalls", 64'(st), 64'd0);
      end
      idle(2);
      check("store_stream_sb_empty", 64'(lsu.sb_empty), 64'd1);

      // Exact-match byte load right after a byte store (forwarded or stalled once)
`ifdef LSU_FWD_EN
      exp_fwd_stall = 0;
`else
      exp_fwd_stall = 1;
`endif
      issue(1'b1, SZ_B, 17'h0020, 32'h0000_0080, 1'b1, st);
      issue(1'b0, SZ_B, 17'h0020, 32'h0, 1'b1, st);
      check("exact_lb_stalls", 64'(st), 64'(exp_fwd_stall));
      issue(1'b0, SZ_BU, 17'h0020, 32'h0, 1'b1, st);
      idle(2);

      // Partial overlap always stalls until the entry drains
      issue(1'b1, SZ_W, 17'h0040, 32'hDEAD_BEEF, 1'b1, st);
      issue(1'b0, SZ_H, 17'h0042, 32'h0, 1'b1, st);
      check("partial_lh_stalls", 64'(st), 64'd1);
      idle(2);

      // Invalid-size store is dropped; invalid-size load returns 0
      issue(1'b1, 3'b011, 17'h0060, 32'hFFFF_FFFF, 1'b1, st);
      check("invalid_store_memwrite", 64'(MemWrite), 64'd0);
      check("invalid_store_sb_empty", 64'(lsu.sb_empty), 64'd1);
      issue(1'b0, SZ_W, 17'h0060, 32'h0, 1'b1, st);
      issue(1'b0, 3'b111, 17'h0060, 32'h0, 1'b1, st);
      idle(2);

      // Randomized mix in a small window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         wr = 1'($urandom_range(0, 1));
         sz = size_tbl[$urandom_range(0, 11)];
         a  = 17'h0200 + 17'($urandom_range(0, 23));
         issue(wr, sz, a, $urandom, 1'b1, st);
         if ($urandom_range(0, 3) == 0) idle(1);
      end

      idle(6);
      check("end_rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
      check("end_store_queue_empty", 64'(st_q.size()), 64'd0);
      check("end_sb_empty", 64'(lsu.sb_empty), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
